miriscv_lsu_split: RTL and testbench

- Load/store unit, successor to the single-cycle LSU.
- Talks to data memory over a req/gnt/rvalid handshake, so memory can take any number of cycles to grant and to respond.
- Parametrised handling of misaligned accesses: either split into two aligned word transactions, or trap.
- Sits between the core's EX/MEM stage (stall, load data) and the data memory or bus.

---
 rtl/miriscv_lsu_pkg.sv | 41 ++++
 rtl/miriscv_lsu_align.sv | 38 +++
 rtl/miriscv_lsu_split.sv | 166 ++++++++++++++++
 tb/tb_miriscv_lsu_split.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/miriscv_lsu_pkg.sv
// Shared types and lane helpers for the handshaking, split-capable load/store unit.
package miriscv_lsu_pkg;

    typedef enum logic [2:0] {
        LDST_B  = 3'd0,
        LDST_H  = 3'd1,
        LDST_W  = 3'd2,
        LDST_BU = 3'd4,
        LDST_HU = 3'd5
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
        REQ1,
        WAIT1
    } lsu_state_e;

    // Byte enables over two consecutive words: [3:0] first word, [6:4] spill into the next.
    function automatic logic [6:0] lsu_be(input logic [2:0] size, input logic [1:0] off);
        logic [6:0] mask;
        case (size)
            LDST_B, LDST_BU: mask = 7'b0000001;
            LDST_H, LDST_HU: mask = 7'b0000011;
            default:         mask = 7'b0001111;
        endcase
        return mask << off;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            LDST_B, LDST_BU: mis = 1'b0;
            LDST_H, LDST_HU: mis = off[0];
            default:         mis = (off != 2'd0);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane steering: byte enables, store data shifting, load extraction/extension.
module miriscv_lsu_align
    import miriscv_lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rword0,
    input  logic [31:0] rword1,
    output logic [6:0]  be,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata_ext
);

    logic [4:0]  shamt;
    logic [63:0] wshift;
    logic [31:0] rsel;

    assign shamt    = {off, 3'b000};
    assign be       = lsu_be(size, off);
    assign wshift   = {32'd0, wdata} << shamt;
    assign wdata_lo = wshift[31:0];
    assign wdata_hi = wshift[63:32];
    assign rsel     = 32'({rword1, rword0} >> shamt);

    always_comb begin
        rdata_ext = rsel;
        case (size)
            LDST_B:  rdata_ext = {{24{rsel[7]}}, rsel[7:0]};
            LDST_BU: rdata_ext = {24'd0, rsel[7:0]};
            LDST_H:  rdata_ext = {{16{rsel[15]}}, rsel[15:0]};
            LDST_HU: rdata_ext = {16'd0, rsel[15:0]};
            default: rdata_ext = rsel;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu_split.sv
// Load/store unit on a req/gnt/rvalid bus; misaligned accesses are split in two or trapped.
module miriscv_lsu_split
    import miriscv_lsu_pkg::*;
#(
    parameter bit MISALIGN_SPLIT = 1'b1,
    parameter int MAX_WAIT       = 255
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_stall_req_o,
    output logic [31:0] lsu_data_o,
    output logic        lsu_misalign_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

    lsu_state_e  state_reg;
    logic [2:0]  size_reg;
    logic [1:0]  off_reg;
    logic        we_reg;
    logic [2:0]  be_hi_reg;
    logic [31:0] wdata_hi_reg;
    logic [31:0] rword0_reg;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic        data_req_reg;
    logic        data_we_reg;
    logic [3:0]  data_be_reg;
    logic [31:0] data_addr_reg;
    logic [31:0] data_wdata_reg;

    logic        in_idle, in_req, in_wait;
    logic        trap, stalled, timeout_hit, resp_done, done;
    logic [2:0]  al_size;
    logic [1:0]  al_off;
    logic [31:0] al_rword0;
    logic [6:0]  al_be;
    logic [31:0] al_wdata_lo, al_wdata_hi, al_rdata;

    assign in_idle = (state_reg == IDLE);
    assign in_req  = (state_reg == REQ0)  || (state_reg == REQ1);
    assign in_wait = (state_reg == WAIT0) || (state_reg == WAIT1);

    // The aligner sees the live request while idle and the latched one afterwards.
    assign al_size   = in_idle ? lsu_size_i : size_reg;
    assign al_off    = in_idle ? lsu_addr_i[1:0] : off_reg;
    assign al_rword0 = (state_reg == WAIT0) ? data_rdata_i : rword0_reg;

    miriscv_lsu_align u_align (
        .size      (al_size),
        .off       (al_off),
        .wdata     (lsu_data_i),
        .rword0    (al_rword0),
        .rword1    (data_rdata_i),
        .be        (al_be),
        .wdata_lo  (al_wdata_lo),
        .wdata_hi  (al_wdata_hi),
        .rdata_ext (al_rdata)
    );

    assign trap        = in_idle && lsu_req_i && !MISALIGN_SPLIT
                         && lsu_misaligned(lsu_size_i, lsu_addr_i[1:0]);
    assign stalled     = (in_req && !data_gnt_i) || (in_wait && !data_rvalid_i);
    assign timeout_hit = (MAX_WAIT != 0) && stalled
                         && (wait_cnt_reg == CNT_W'(MAX_WAIT - 1));
    assign resp_done   = data_rvalid_i && ((state_reg == WAIT1) ||
                         ((state_reg == WAIT0) && ((be_hi_reg == 3'd0) || data_err_i)));
    assign done        = trap || resp_done || timeout_hit;

    assign lsu_stall_req_o = lsu_req_i & ~done;
    assign lsu_misalign_o  = trap;
    assign lsu_err_o       = timeout_hit || (in_wait && data_rvalid_i && data_err_i);
    assign lsu_data_o      = (resp_done && !we_reg) ? al_rdata : 32'd0;

    assign data_req_o   = data_req_reg;
    assign data_we_o    = data_we_reg;
    assign data_be_o    = data_be_reg;
    assign data_addr_o  = data_addr_reg;
    assign data_wdata_o = data_wdata_reg;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_reg      <= IDLE;
            size_reg       <= 3'd0;
            off_reg        <= 2'd0;
            we_reg         <= 1'b0;
            be_hi_reg      <= 3'd0;
            wdata_hi_reg   <= 32'd0;
            rword0_reg     <= 32'd0;
            wait_cnt_reg   <= '0;
            data_req_reg   <= 1'b0;
            data_we_reg    <= 1'b0;
            data_be_reg    <= 4'd0;
            data_addr_reg  <= 32'd0;
            data_wdata_reg <= 32'd0;
        end else begin
            wait_cnt_reg <= (stalled && !timeout_hit) ? wait_cnt_reg + 1'b1 : '0;
            case (state_reg)
                IDLE: begin
                    if (lsu_req_i && !trap) begin
                        size_reg       <= lsu_size_i;
                        off_reg        <= lsu_addr_i[1:0];
                        we_reg         <= lsu_we_i;
                        be_hi_reg      <= al_be[6:4];
                        wdata_hi_reg   <= al_wdata_hi;
                        data_req_reg   <= 1'b1;
                        data_we_reg    <= lsu_we_i;
                        data_be_reg    <= al_be[3:0];
                        data_addr_reg  <= {lsu_addr_i[31:2], 2'b00};
                        data_wdata_reg <= al_wdata_lo;
                        state_reg      <= REQ0;
                    end
                end
                REQ0, REQ1: begin
                    if (data_gnt_i) begin
                        data_req_reg <= 1'b0;
                        state_reg    <= (state_reg == REQ0) ? WAIT0 : WAIT1;
                    end else if (timeout_hit) begin
                        data_req_reg <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                WAIT0: begin
                    if (data_rvalid_i) begin
                        rword0_reg <= data_rdata_i;
                        if (be_hi_reg != 3'd0 && !data_err_i) begin
                            data_req_reg   <= 1'b1;
                            data_addr_reg  <= data_addr_reg + 32'd4;
                            data_be_reg    <= {1'b0, be_hi_reg};
                            data_wdata_reg <= wdata_hi_reg;
                            state_reg      <= REQ1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        state_reg <= IDLE;
                    end
                end
                WAIT1: begin
                    if (data_rvalid_i || timeout_hit) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The core must hold its request for the whole transaction.
    assert property (@(posedge clk_i) disable iff (!arstn_i) !in_idle |-> lsu_req_i);

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Directed bench for miriscv_lsu_split with a configurable-latency memory responder.
module tb_miriscv_lsu_split;

    logic        clk = 1'b0;
    logic        arstn;
    logic        lsu_req, lsu_we, ns_req;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_stall, lsu_misalign, lsu_err;
    logic [31:0] lsu_rdata;
    logic        data_req_o, data_gnt_i, data_rvalid_i, data_err_i, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;

    logic        ns_stall, ns_misalign, ns_err, ns_data_req, ns_data_we;
    logic [31:0] ns_rdata, ns_data_addr, ns_data_wdata;
    logic [3:0]  ns_data_be;

    always #5 clk = ~clk;

    miriscv_lsu_split #(.MISALIGN_SPLIT(1'b1), .MAX_WAIT(4)) dut (
        .clk_i(clk), .arstn_i(arstn),
        .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
        .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wdata),
        .lsu_stall_req_o(lsu_stall), .lsu_data_o(lsu_rdata),
        .lsu_misalign_o(lsu_misalign), .lsu_err_o(lsu_err),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i),
        .data_err_i(data_err_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i)
    );

    miriscv_lsu_split #(.MISALIGN_SPLIT(1'b0), .MAX_WAIT(0)) dut_ns (
        .clk_i(clk), .arstn_i(arstn),
        .lsu_req_i(ns_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
        .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wdata),
        .lsu_stall_req_o(ns_stall), .lsu_data_o(ns_rdata),
        .lsu_misalign_o(ns_misalign), .lsu_err_o(ns_err),
        .data_req_o(ns_data_req), .data_gnt_i(1'b0), .data_rvalid_i(1'b0),
        .data_err_i(1'b0), .data_we_o(ns_data_we), .data_be_o(ns_data_be),
        .data_addr_o(ns_data_addr), .data_wdata_o(ns_data_wdata), .data_rdata_i(32'd0)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder state
    logic [31:0] mem [0:255];
    int          gnt_delay = 0, rvalid_delay = 0;
    bit          gnt_never = 0, resp_err = 0;
    bit          pending = 0;
    int          g_cnt = 0, r_cnt = 0;
    logic [7:0]  resp_idx;
    int          txn_cnt = 0;
    logic [31:0] log_addr [0:63];
    logic [31:0] log_wdata [0:63];
    logic [3:0]  log_be [0:63];
    logic [31:0] snap_addr, snap_wdata;
    logic [4:0]  snap_ctl;

    initial begin
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'd0;
        forever begin
            @(negedge clk);
            data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_err_i = 1'b0; data_rdata_i = 32'd0;
            if (!arstn) begin
                pending = 0; g_cnt = 0; r_cnt = 0;
            end else if (pending) begin
                if (r_cnt == rvalid_delay) begin
                    data_rvalid_i = 1'b1;
                    data_err_i    = resp_err;
                    data_rdata_i  = mem[resp_idx];
                    pending = 0; r_cnt = 0;
                end else begin
                    r_cnt++;
                end
            end else if (data_req_o) begin
                if (g_cnt == 0) begin
                    snap_addr = data_addr_o; snap_wdata = data_wdata_o; snap_ctl = {data_we_o, data_be_o};
                end else begin
                    check("stable_addr", data_addr_o, snap_addr);
                    check("stable_wdata", data_wdata_o, snap_wdata);
                    check("stable_we_be", {27'd0, data_we_o, data_be_o}, {27'd0, snap_ctl});
                end
                if (!gnt_never && g_cnt == gnt_delay) begin
                    data_gnt_i = 1'b1;
                    log_addr[txn_cnt] = data_addr_o;
                    log_wdata[txn_cnt] = data_wdata_o;
                    log_be[txn_cnt] = data_be_o;
                    txn_cnt++;
                    resp_idx = data_addr_o[9:2];
                    if (data_we_o) begin
                        for (int b = 0; b < 4; b++)
                            if (data_be_o[b]) mem[resp_idx][8*b +: 8] = data_wdata_o[8*b +: 8];
                    end
                    pending = 1; g_cnt = 0;
                end else begin
                    g_cnt++;
                end
            end else begin
                g_cnt = 0;
            end
        end
    end

    // Runs one core request; returns cycles to done (inclusive), data, pulses and bus log base.
    task automatic do_op(input string name, input logic we, input logic [2:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int cycles, output logic [31:0] rdata, output logic err,
                         output int req_cycles, output int base);
        bit finished = 0;
        @(negedge clk);
        base = txn_cnt;
        lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
        cycles = 0; req_cycles = 0; rdata = 32'd0; err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #2;
            cycles++;
            if (data_req_o) req_cycles++;
            if (!lsu_stall) begin
                rdata = lsu_rdata; err = lsu_err; finished = 1;
                break;
            end
            @(negedge clk);
        end
        check({name, "_completes"}, {31'd0, finished}, 32'd1);
        @(negedge clk);
        lsu_req = 1'b0;
        $display("op %-10s we=%0d size=%0d addr=0x%08h wdata=0x%08h -> cycles=%0d rdata=0x%08h err=%0d txns=%0d",
                 name, we, size, addr, wdata, cycles, rdata, err, txn_cnt - base);
    endtask

    int          cyc, reqc, base;
    logic [31:0] rd;
    logic        er;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        arstn = 1'b0; lsu_req = 1'b0; ns_req = 1'b0; lsu_we = 1'b0;
        lsu_size = 3'd0; lsu_addr = 32'd0; lsu_wdata = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        check("rst_stall", {31'd0, lsu_stall}, 32'd0);
        check("rst_data_req", {31'd0, data_req_o}, 32'd0);
        check("rst_bus", {data_addr_o ^ data_wdata_o}, 32'd0);
        check("rst_be_we", {27'd0, data_we_o, data_be_o}, 32'd0);
        check("rst_lsu_out", {lsu_rdata[31:2], lsu_err, lsu_misalign}, 32'd0);
        lsu_req = 1'b1;
        #1;
        check("rst_stall_follows_req", {31'd0, lsu_stall}, 32'd1);
        lsu_req = 1'b0;
        @(negedge clk);
        arstn = 1'b1;

        // Aligned LW, zero-wait
        mem[8'h40] = 32'h11223344;
        do_op("lw_100", 1'b0, 3'd2, 32'h100, 32'd0, cyc, rd, er, reqc, base);
        check("lw_data", rd, 32'h11223344);
        check("lw_stall_cycles", cyc - 1, 2);
        check("lw_addr", log_addr[base], 32'h100);
        check("lw_be", {28'd0, log_be[base]}, 32'hF);
        check("lw_txns", txn_cnt - base, 1);

        // Byte loads at top lane
        mem[8'h40] = 32'h80FFFFFF;
        do_op("lb_103", 1'b0, 3'd0, 32'h103, 32'd0, cyc, rd, er, reqc, base);
        check("lb_data", rd, 32'hFFFFFF80);
        check("lb_be", {28'd0, log_be[base]}, 32'h8);
        do_op("lbu_103", 1'b0, 3'd4, 32'h103, 32'd0, cyc, rd, er, reqc, base);
        check("lbu_data", rd, 32'h00000080);

        // Split store
        mem[8'h41] = 32'd0;
        do_op("sw_102", 1'b1, 3'd2, 32'h102, 32'hAABBCCDD, cyc, rd, er, reqc, base);
        check("sw_txns", txn_cnt - base, 2);
        check("sw_addr0", log_addr[base], 32'h100);
        check("sw_be0", {28'd0, log_be[base]}, 32'hC);
        check("sw_wdata0", log_wdata[base], 32'hCCDD0000);
        check("sw_addr1", log_addr[base+1], 32'h104);
        check("sw_be1", {28'd0, log_be[base+1]}, 32'h3);
        check("sw_wdata1", log_wdata[base+1], 32'h0000AABB);
        check("sw_cycles", cyc, 5);
        check("sw_lsu_data", rd, 32'd0);
        check("sw_mem0", mem[8'h40], 32'hCCDDFFFF);
        check("sw_mem1", mem[8'h41], 32'h0000AABB);

        // Split loads across the word boundary
        do_op("lw_102", 1'b0, 3'd2, 32'h102, 32'd0, cyc, rd, er, reqc, base);
        check("lw_split_data", rd, 32'hAABBCCDD);
        check("lw_split_cycles", cyc, 5);
        do_op("lh_103", 1'b0, 3'd1, 32'h103, 32'd0, cyc, rd, er, reqc, base);
        check("lh_split_data", rd, 32'hFFFFBBCC);
        check("lh_split_be0", {28'd0, log_be[base]}, 32'h8);
        check("lh_split_be1", {28'd0, log_be[base+1]}, 32'h1);
        do_op("lhu_103", 1'b0, 3'd5, 32'h103, 32'd0, cyc, rd, er, reqc, base);
        check("lhu_split_data", rd, 32'h0000BBCC);

        // Slow memory: grant after 3 wait cycles, response after 2
        mem[8'hC0] = 32'hDEADBEEF;
        gnt_delay = 3; rvalid_delay = 2;
        do_op("lw_300_slow", 1'b0, 3'd2, 32'h300, 32'd0, cyc, rd, er, reqc, base);
        check("slow_data", rd, 32'hDEADBEEF);
        check("slow_cycles", cyc, 8);
        check("slow_req_cycles", reqc, 4);
        check("slow_err", {31'd0, er}, 32'd0);
        gnt_delay = 0; rvalid_delay = 0;

        // Bus error on the first half of a split: second half skipped
        resp_err = 1;
        do_op("lw_102_err", 1'b0, 3'd2, 32'h102, 32'd0, cyc, rd, er, reqc, base);
        check("buserr_err", {31'd0, er}, 32'd1);
        check("buserr_cycles", cyc, 3);
        check("buserr_txns", txn_cnt - base, 1);
        resp_err = 0;

        // Grant timeout
        gnt_never = 1;
        do_op("lw_timeout", 1'b0, 3'd2, 32'h100, 32'd0, cyc, rd, er, reqc, base);
        check("timeout_err", {31'd0, er}, 32'd1);
        check("timeout_req_cycles", reqc, 4);
        check("timeout_cycles", cyc, 5);
        #2;
        check("timeout_req_dropped", {31'd0, data_req_o}, 32'd0);
        check("timeout_err_one_pulse", {31'd0, lsu_err}, 32'd0);
        gnt_never = 0;

        // Trap instead of split
        @(negedge clk);
        ns_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd1; lsu_addr = 32'h203;
        #2;
        check("trap_misalign", {31'd0, ns_misalign}, 32'd1);
        check("trap_stall", {31'd0, ns_stall}, 32'd0);
        check("trap_data_req", {31'd0, ns_data_req}, 32'd0);
        $display("op lh_203_trap misalign=%0d stall=%0d", ns_misalign, ns_stall);
        @(negedge clk);
        ns_req = 1'b0;
        #2;
        check("trap_pulse_ends", {31'd0, ns_misalign}, 32'd0);
        check("trap_no_bus", {31'd0, ns_data_req}, 32'd0);

        // Reset while waiting for the second response
        rvalid_delay = 3;
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'd2; lsu_addr = 32'h102;
        base = txn_cnt;
        for (int i = 0; i < 30 && txn_cnt - base < 2; i++) @(negedge clk);
        check("rstmid_reach_req1", txn_cnt - base, 2);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        check("rstmid_data_req", {31'd0, data_req_o}, 32'd0);
        check("rstmid_err", {31'd0, lsu_err}, 32'd0);
        lsu_req = 1'b0;
        $display("op rst_in_wait1 data_req=%0d", data_req_o);
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        rvalid_delay = 0;
        @(negedge clk);
        #2;
        check("rstmid_idle_no_req", {31'd0, data_req_o}, 32'd0);
        mem[8'h40] = 32'h13579BDF;
        do_op("lw_after_rst", 1'b0, 3'd2, 32'h100, 32'd0, cyc, rd, er, reqc, base);
        check("after_rst_data", rd, 32'h13579BDF);
        check("after_rst_cycles", cyc, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

endmodule
